soc_system_pll_rst_seq: RTL

Parametrised PLL supervisor and reset sequencer that sits beside the SDRAM/system PLL in `soc_system`. It drives the PLL reset and qualifies its asynchronous `locked` output. It releases one reset per PLL output clock in a fixed staggered order. It retries the PLL on lock timeout and re-sequences on lock loss, giving downstream logic one clean "clocks good" indication instead of raw `locked`.

---
 rtl/soc_system_pll_rst_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/soc_system_pll_rst_seq.sv
// PLL supervisor and reset sequencer: qualifies pll_locked, retries the PLL on
// lock timeout and releases one reset per PLL output clock in staggered order.
module soc_system_pll_rst_seq #(
   parameter int unsigned NUM_CHANNELS        = 2,
   parameter int unsigned SYNC_STAGES         = 2,
   parameter int unsigned PLL_RST_CYCLES      = 32,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned CHAN_GAP_CYCLES     = 16,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned MAX_RETRIES         = 3
) (
   input  logic                               refclk,
   input  logic                               rst,
   input  logic                               pll_locked,
   input  logic                               force_relock,
   output logic                               pll_rst,
   output logic [NUM_CHANNELS-1:0]            chan_rst,
   output logic                               all_ready,
   output logic                               fault,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
   output logic [7:0]                         lock_loss_count
);

   localparam int unsigned CNT_MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > CHAN_GAP_CYCLES) ? CNT_MAX_A : CHAN_GAP_CYCLES;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned TO_W      = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int unsigned CH_W      = $clog2(NUM_CHANNELS + 1);
   localparam int unsigned RC_W      = $clog2(MAX_RETRIES + 1);

   localparam logic [2:0] S_PLL_RST   = 3'd0;
   localparam logic [2:0] S_WAIT_LOCK = 3'd1;
   localparam logic [2:0] S_STABLE    = 3'd2;
   localparam logic [2:0] S_RELEASE   = 3'd3;
   localparam logic [2:0] S_RUN       = 3'd4;
   localparam logic [2:0] S_FAULT     = 3'd5;

   logic [SYNC_STAGES-1:0]  sync_q;
   logic                    lock_s;
   logic [2:0]              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [TO_W-1:0]         to_q, to_d;
   logic [CH_W-1:0]         ch_q, ch_d;
   logic [RC_W-1:0]         retry_q, retry_d, retry_inc;
   logic [7:0]              llc_q, llc_d;
   logic [NUM_CHANNELS-1:0] chan_rst_q, chan_rst_d;
   logic                    pll_rst_q, pll_rst_d;
   logic                    all_ready_q, all_ready_d;
   logic                    fault_q, fault_d;
   logic                    timeout;

   assign lock_s = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      to_d       = to_q;
      ch_d       = ch_q;
      retry_d    = retry_q;
      llc_d      = llc_q;
      chan_rst_d = chan_rst_q;
      retry_inc  = retry_q + 1'b1;
      timeout    = ((state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) &&
                   (to_q == TO_W'(LOCK_TIMEOUT_CYCLES - 1));

      if (force_relock) begin
         state_d = S_PLL_RST;
         cnt_d   = '0;
         retry_d = '0;
      end else if (timeout) begin
         retry_d = retry_inc;
         cnt_d   = '0;
         state_d = (retry_inc == RC_W'(MAX_RETRIES)) ? S_FAULT : S_PLL_RST;
      end else if (((state_q == S_RELEASE) || (state_q == S_RUN)) && !lock_s) begin
         state_d = S_PLL_RST;
         cnt_d   = '0;
         if (llc_q != 8'hff) llc_d = llc_q + 8'd1;
      end else begin
         case (state_q)
            S_PLL_RST: begin
               if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                  state_d = S_WAIT_LOCK;
                  cnt_d   = '0;
                  to_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            S_WAIT_LOCK: begin
               to_d = to_q + 1'b1;
               if (lock_s) begin
                  state_d = S_STABLE;
                  cnt_d   = '0;
               end
            end
            // Timeout budget keeps running across lock glitches within one attempt
            S_STABLE: begin
               to_d = to_q + 1'b1;
               if (!lock_s) begin
                  state_d = S_WAIT_LOCK;
               end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                  state_d = S_RELEASE;
                  cnt_d   = '0;
                  ch_d    = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            // ch_q is the next channel to release; cnt_q counts down the gap
            S_RELEASE: begin
               if (ch_q == CH_W'(NUM_CHANNELS)) begin
                  state_d = S_RUN;
               end else if (cnt_q == '0) begin
                  for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                     if (CH_W'(i) == ch_q) chan_rst_d[i] = 1'b0;
                  end
                  ch_d  = ch_q + 1'b1;
                  cnt_d = CNT_W'(CHAN_GAP_CYCLES - 1);
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            S_RUN:   ;
            S_FAULT: ;
            default: state_d = S_PLL_RST;
         endcase
      end

      if ((state_d != S_RELEASE) && (state_d != S_RUN)) chan_rst_d = '1;
      pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAULT);
      all_ready_d = (state_d == S_RUN);
      fault_d     = (state_d == S_FAULT);
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync_q      <= '0;
         state_q     <= S_PLL_RST;
         cnt_q       <= '0;
         to_q        <= '0;
         ch_q        <= '0;
         retry_q     <= '0;
         llc_q       <= '0;
         chan_rst_q  <= '1;
         pll_rst_q   <= 1'b1;
         all_ready_q <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_locked};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         to_q        <= to_d;
         ch_q        <= ch_d;
         retry_q     <= retry_d;
         llc_q       <= llc_d;
         chan_rst_q  <= chan_rst_d;
         pll_rst_q   <= pll_rst_d;
         all_ready_q <= all_ready_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_rst         = pll_rst_q;
   assign chan_rst        = chan_rst_q;
   assign all_ready       = all_ready_q;
   assign fault           = fault_q;
   assign retry_count     = retry_q;
   assign lock_loss_count = llc_q;

endmodule
